input_debouncer: RTL and testbench

- Conditions a raw, asynchronous push-button/switch level into the clean, synchronous `x` input consumed by the downstream Idle/Start/Stop sequence FSM.
- Synchronizes the raw input, then requires it to stay stable for a programmable number of cycles before the output level changes.
- Emits single-cycle rise/fall pulses alongside the debounced level.

---
 rtl/input_debouncer_pkg.sv | 22 ++
 rtl/sync_ff.sv | 31 +++
 rtl/input_debouncer.sv | 150 +++++++++++++++
 tb/tb_input_debouncer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// ============================================================================
//  Module   : input_debouncer_pkg
//  Brief    : Shared state encoding and glitch-counter sizing for the debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam int                    c_GLITCH_W   = 8;
  localparam logic [c_GLITCH_W-1:0] c_GLITCH_MAX = '1;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
//  Module   : sync_ff
//  Brief    : SYNC_STAGES-deep flop chain bringing an async level into clk.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic ar,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
//  Module   : input_debouncer
//  Brief    : Synchronize + debounce a raw switch level; emits level and edges.
//             INPUT_DEBOUNCER_GLITCH_COUNT_EN adds the glitch_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic ar,
  input  logic din,
  input  logic en,
  output logic x,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
  ,
  output logic [c_GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic             w_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_x, w_x_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic             r_busy;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .ar (ar),
    .d  (din),
    .q  (w_s)
  );

  // With en low everything falls through to the hold defaults.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (en) begin
      case (r_state)
        LOW: begin
          if (w_s) begin
            w_state_nxt = WAIT_HIGH;
            w_cnt_nxt   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!w_s) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
            w_x_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        HIGH: begin
          if (!w_s) begin
            w_state_nxt = WAIT_LOW;
            w_cnt_nxt   = '0;
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
            w_x_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
          w_x_nxt     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
    end
  end

  assign x    = r_x;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
  logic                  w_glitch;
  logic [c_GLITCH_W-1:0] r_glitch_cnt;

  // An abort is a WAIT_* state seeing the origin level again.
  assign w_glitch = en && (((r_state == WAIT_HIGH) && !w_s) ||
                           ((r_state == WAIT_LOW)  &&  w_s));

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != c_GLITCH_MAX)) begin
      r_glitch_cnt <= r_glitch_cnt + c_GLITCH_W'(1);
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
//  Module   : tb_input_debouncer
//  Brief    : Directed self-checking bench, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;

  logic clk;
  logic ar;
  logic din;
  logic en;
  logic x;
  logic rise;
  logic fall;
  logic busy;
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
  logic [7:0] glitch_cnt;
`endif

  int tests;
  int fails;

  // Packed as {din, en, exp_x, exp_rise, exp_fall, exp_busy}
  typedef struct packed {
    logic din;
    logic en;
    logic x;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs [27];

  input_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk (clk),
    .ar  (ar),
    .din (din),
    .en  (en),
    .x   (x),
    .rise(rise),
    .fall(fall),
    .busy(busy)
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic d, input logic e);
    din = d;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int ex, input int er,
                          input int ef, input int eb);
    chk($sformatf("%s x", tag),    int'(x),    ex);
    chk($sformatf("%s rise", tag), int'(rise), er);
    chk($sformatf("%s fall", tag), int'(fall), ef);
    chk($sformatf("%s busy", tag), int'(busy), eb);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ar    = 1'b1;
    din   = 1'b0;
    en    = 1'b1;

    // clean rise (1-8), clean fall (9-16), bounce then steady rise (17-27)
    vecs = '{
      6'b110000, 6'b110000, 6'b110001, 6'b110001, 6'b110001, 6'b110001,
      6'b111100, 6'b111000,
      6'b011000, 6'b011000, 6'b011001, 6'b011001, 6'b011001, 6'b011001,
      6'b010010, 6'b010000,
      6'b110000, 6'b110000, 6'b010001, 6'b110001, 6'b110000, 6'b110001,
      6'b110001, 6'b110001, 6'b110001, 6'b111100, 6'b111000
    };

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0);
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    chk("reset glitch_cnt", int'(glitch_cnt), 0);
`endif
    ar = 1'b0;

    for (int i = 0; i < 27; i++) begin
      step(vecs[i].din, vecs[i].en);
      chk_outs($sformatf("vec%0d", i + 1), int'(vecs[i].x), int'(vecs[i].rise),
               int'(vecs[i].fall), int'(vecs[i].busy));
    end
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    chk("bounce glitch_cnt", int'(glitch_cnt), 1);
`endif

    // Enable hold: en low after edge 5 for 10 edges, rise 2 edges after return
    repeat (8) step(1'b0, 1'b1);
    chk("pre_en x", int'(x), 0);
    for (int k = 1; k <= 25; k++) begin
      step(1'b1, (k >= 6 && k <= 15) ? 1'b0 : 1'b1);
      chk_outs($sformatf("en_hold%0d", k), (k >= 17) ? 1 : 0, (k == 17) ? 1 : 0,
               0, (k >= 3 && k <= 16) ? 1 : 0);
    end

    // Async reset while qualifying with cnt=2
    repeat (8) step(1'b0, 1'b1);
    chk("pre_ar x", int'(x), 0);
    repeat (5) step(1'b1, 1'b1);
    chk("pre_ar busy", int'(busy), 1);
    ar = 1'b1;
    #2;
    chk_outs("ar_abort", 0, 0, 0, 0);
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    chk("ar glitch_cnt", int'(glitch_cnt), 0);
`endif
    ar = 1'b0;
    #2;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      chk_outs($sformatf("ar_restart%0d", k), (k >= 7) ? 1 : 0, (k == 7) ? 1 : 0,
               0, (k >= 3 && k <= 6) ? 1 : 0);
    end

`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
    repeat (8) step(1'b0, 1'b1);
    for (int p = 0; p < 300; p++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk($sformatf("sat%0d x", p), int'(x), 0);
      if (p == 99) begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("glitch_cnt after 100", int'(glitch_cnt), 100);
      end
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("glitch_cnt saturated", int'(glitch_cnt), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
